// File: rtl/gardner_pkg.sv
// Shared encodings and the saturation helper for the Gardner symbol-timing loop.
package gardner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_TRACK = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ADJ_NONE  = 2'b00,
    ADJ_SKIP  = 2'b01,
    ADJ_STUFF = 2'b10
  } adj_t;

  localparam int PHASE_W = 5;
  localparam int SAT_W   = 64;

  // Clamp a wide signed value to the symmetric range +/-(2^(w-1)-1).
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int                      w);
    logic signed [SAT_W-1:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/gardner_loop_filter.sv
// PI loop filter and overflow accumulator; turns captured timing errors into
// pending skip/stuff decisions for the phase counter.
module gardner_loop_filter
  import gardner_pkg::*;
#(
  parameter int                      WIDTH    = 16,
  parameter int                      ACC_W    = 24,
  parameter logic signed [ACC_W-1:0] THRESH   = 24'sd2048,
  parameter int                      KP_SHIFT = 2,
  parameter int                      KI_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    cap,
  input  logic                    track,
  input  logic                    apply,
  input  logic signed [WIDTH-1:0] error_n,
  output logic signed [WIDTH-1:0] e_reg,
  output logic                    upd,
  output adj_t                    pending
);

  logic signed [ACC_W-1:0] integ, acc;
  logic signed [ACC_W-1:0] e_ext, p_term, i_term, integ_nx, acc_sum, acc_nx;
  logic                    track_q;
  int                      kp, ki;
  adj_t                    dec;

  always_comb begin
    kp       = track_q ? KP_SHIFT + 2 : KP_SHIFT;
    ki       = track_q ? KI_SHIFT + 2 : KI_SHIFT;
    e_ext    = {{(ACC_W - WIDTH){e_reg[WIDTH-1]}}, e_reg};
    p_term   = e_ext >>> kp;
    i_term   = e_ext >>> ki;
    integ_nx = ACC_W'(sat(SAT_W'(integ) + SAT_W'(i_term), ACC_W));
    acc_sum  = ACC_W'(sat(SAT_W'(acc) + SAT_W'(p_term) + SAT_W'(integ_nx), ACC_W));
    acc_nx   = acc_sum;
    dec      = ADJ_NONE;
    if (acc_sum >= THRESH) begin
      acc_nx = acc_sum - THRESH;
      dec    = ADJ_SKIP;
    end else if (acc_sum <= -THRESH) begin
      acc_nx = acc_sum + THRESH;
      dec    = ADJ_STUFF;
    end
  end

  // Gain set is latched with the error so a symbol keeps the gains it was captured under.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_reg   <= '0;
      track_q <= 1'b0;
      upd     <= 1'b0;
      integ   <= '0;
      acc     <= '0;
      pending <= ADJ_NONE;
    end else if (clr) begin
      e_reg   <= '0;
      track_q <= 1'b0;
      upd     <= 1'b0;
      integ   <= '0;
      acc     <= '0;
      pending <= ADJ_NONE;
    end else begin
      upd <= cap;
      if (cap) begin
        e_reg   <= error_n;
        track_q <= track;
      end
      if (upd) begin
        integ <= integ_nx;
        acc   <= acc_nx;
      end
      if (upd && dec != ADJ_NONE) pending <= dec;
      else if (apply)             pending <= ADJ_NONE;
    end
  end

endmodule

// File: rtl/gardner_timing_ctrl.sv
// Gardner symbol-timing controller: 32-phase counter, strobes, acquisition FSM, lock detect.
// Define GARDNER_LOCK_DET_EN to build the lock detector; otherwise locked is tied low.
//
// state    | meaning
// ST_IDLE  | loop disabled, phase/filter/counters cleared
// ST_ACQ   | acquisition gains, counting down ACQ_SYMS symbols
// ST_TRACK | tracking gains, lock detector may assert
module gardner_timing_ctrl
  import gardner_pkg::*;
#(
  parameter int                      WIDTH     = 16,
  parameter int                      ACC_W     = 24,
  parameter logic signed [ACC_W-1:0] THRESH    = 24'sd2048,
  parameter int                      KP_SHIFT  = 2,
  parameter int                      KI_SHIFT  = 6,
  parameter int                      ACQ_SYMS  = 256,
  parameter int                      ERR_LAT   = 1,
  parameter logic signed [WIDTH-1:0] LOCK_THR  = 16'sd512,
  parameter int                      LOCK_SYMS = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] error_n,
  output logic                    sym_strobe,
  output logic                    mid_strobe,
  output logic [4:0]              phase,
  output logic [1:0]              adj,
  output logic [1:0]              state,
  output logic                    locked
);

  localparam int               CNT_W    = $clog2(ACQ_SYMS + 1);
  localparam logic [CNT_W-1:0] ACQ_LOAD = CNT_W'(ACQ_SYMS - 1);

  state_t                  state_q;
  adj_t                    adj_q, pending;
  logic [PHASE_W-1:0]      phase_q;
  logic [CNT_W-1:0]        sym_left;
  logic [ERR_LAT-1:0]      cap_pipe;
  logic [PHASE_W:0]        step, sum;
  logic                    active, wrap, mid_x;
  logic signed [WIDTH-1:0] e_reg;
  logic                    upd;

  assign active = en && (state_q != ST_IDLE);

  always_comb begin
    case (pending)
      ADJ_SKIP:  step = 6'd2;
      ADJ_STUFF: step = 6'd0;
      default:   step = 6'd1;
    endcase
    sum   = {1'b0, phase_q} + step;
    wrap  = sum[PHASE_W];
    mid_x = !phase_q[PHASE_W-1] && sum[PHASE_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      sym_strobe <= 1'b0;
      mid_strobe <= 1'b0;
      adj_q      <= ADJ_NONE;
      sym_left   <= ACQ_LOAD;
      cap_pipe   <= '0;
    end else if (!en) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      sym_strobe <= 1'b0;
      mid_strobe <= 1'b0;
      adj_q      <= ADJ_NONE;
      sym_left   <= ACQ_LOAD;
      cap_pipe   <= '0;
    end else begin
      sym_strobe <= 1'b0;
      mid_strobe <= 1'b0;
      adj_q      <= ADJ_NONE;
      case (state_q)
        ST_ACQ, ST_TRACK: begin
          // bit 0 mirrors sym_strobe; the last bit marks the capture clock
          cap_pipe <= ERR_LAT'({cap_pipe, sample_valid && wrap});
          if (sample_valid) begin
            phase_q    <= sum[PHASE_W-1:0];
            sym_strobe <= wrap;
            mid_strobe <= mid_x;
            adj_q      <= pending;
          end
          if (state_q == ST_ACQ && sym_strobe) begin
            if (sym_left == '0) state_q  <= ST_TRACK;
            else                sym_left <= sym_left - 1'b1;
          end
        end
        default: begin
          state_q  <= ST_ACQ;
          phase_q  <= '0;
          sym_left <= ACQ_LOAD;
          cap_pipe <= '0;
        end
      endcase
    end
  end

  gardner_loop_filter #(
    .WIDTH    (WIDTH),
    .ACC_W    (ACC_W),
    .THRESH   (THRESH),
    .KP_SHIFT (KP_SHIFT),
    .KI_SHIFT (KI_SHIFT)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!active),
    .cap     (cap_pipe[ERR_LAT-1]),
    .track   (state_q == ST_TRACK),
    .apply   (active && sample_valid),
    .error_n (error_n),
    .e_reg   (e_reg),
    .upd     (upd),
    .pending (pending)
  );

  assign phase = phase_q;
  assign adj   = adj_q;
  assign state = state_q;

`ifdef GARDNER_LOCK_DET_EN
  localparam int LK_W = $clog2(LOCK_SYMS + 1);

  logic [LK_W-1:0]       lock_cnt;
  logic signed [WIDTH:0] e_wide, e_abs;

  // One extra bit keeps |most-negative error| representable.
  always_comb begin
    e_wide = (WIDTH + 1)'(e_reg);
    e_abs  = (e_wide < 0) ? -e_wide : e_wide;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                lock_cnt <= '0;
    else if (!active)          lock_cnt <= '0;
    else if (upd) begin
      if (e_abs < (WIDTH + 1)'(LOCK_THR)) begin
        if (lock_cnt != LK_W'(LOCK_SYMS)) lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  assign locked = (lock_cnt == LK_W'(LOCK_SYMS)) && (state_q == ST_TRACK);
`else
  logic unused_lock;
  assign unused_lock = ^{e_reg, upd, LOCK_THR, (LOCK_SYMS != 0)};
  assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_gardner_timing_ctrl.sv
// Directed bench for gardner_timing_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_gardner_timing_ctrl;

  logic               clk = 1'b0;
  logic               rst_n, en, sample_valid;
  logic signed [15:0] error_n;
  logic               sym_strobe, mid_strobe, locked;
  logic [4:0]         phase;
  logic [1:0]         adj, state;

  int errors = 0;
  int checks = 0;

  int t_sym[1:4];
  int nsym, t_mid1, t_adj, adj1, ph_adj, sym_at_adj, n_skip, n_stuff;

  typedef struct {
    int en_v; int sv; int err; int ncyc;
    int ph; int sym; int mid; int adjv; int st;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  gardner_timing_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_valid (sample_valid),
    .error_n      (error_n),
    .sym_strobe   (sym_strobe),
    .mid_strobe   (mid_strobe),
    .phase        (phase),
    .adj          (adj),
    .state        (state),
    .locked       (locked)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle();
    en = 1'b0;
    sample_valid = 1'b0;
    cyc1();
  endtask

  task automatic wait_syms(input int n, input int bound, output int ok);
    int k = 0;
    ok = 0;
    for (int c = 0; c < bound; c++) begin
      cyc1();
      if (sym_strobe) k++;
      if (k == n) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Enable from IDLE and log strobe/adjust timing; cycle c is the c-th edge after enabling.
  task automatic run_meas(input int err, input int sv_div);
    nsym = 0; t_mid1 = -1; t_adj = -1; adj1 = -1; ph_adj = -1; sym_at_adj = -1;
    n_skip = 0; n_stuff = 0;
    for (int i = 1; i <= 4; i++) t_sym[i] = -1;
    en = 1'b1;
    error_n = 16'(err);
    for (int c = 1; c <= 600 && nsym < 4; c++) begin
      sample_valid = ((c - 1) % sv_div) == 0;
      cyc1();
      if (sym_strobe) begin
        nsym++;
        t_sym[nsym] = c;
      end
      if (mid_strobe && t_mid1 < 0) t_mid1 = c;
      if (adj == 2'b01) n_skip++;
      if (adj == 2'b10) n_stuff++;
      if (adj != 2'b00 && t_adj < 0) begin
        t_adj = c; adj1 = int'(adj); ph_adj = int'(phase); sym_at_adj = int'(sym_strobe);
      end
    end
    sample_valid = 1'b1;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok, last_sym, t256, bad_per, bad_mid, bad_adj, bad_st, bad_hold;

    //            en sv err n   ph sym mid adj st
    vecs[0]  = '{0, 0, 0, 1,   0,  0,  0,  0,  0};
    vecs[1]  = '{1, 1, 0, 1,   0,  0,  0,  0,  1};
    vecs[2]  = '{1, 1, 0, 15,  15, 0,  0,  0,  1};
    vecs[3]  = '{1, 1, 0, 1,   16, 0,  1,  0,  1};
    vecs[4]  = '{1, 1, 0, 1,   17, 0,  0,  0,  1};
    vecs[5]  = '{1, 1, 0, 14,  31, 0,  0,  0,  1};
    vecs[6]  = '{1, 1, 0, 1,   0,  1,  0,  0,  1};
    vecs[7]  = '{1, 1, 0, 1,   1,  0,  0,  0,  1};
    vecs[8]  = '{1, 0, 0, 5,   1,  0,  0,  0,  1};
    vecs[9]  = '{1, 1, 0, 15,  16, 0,  1,  0,  1};
    vecs[10] = '{0, 1, 0, 1,   0,  0,  0,  0,  0};
    vecs[11] = '{0, 0, 0, 1,   0,  0,  0,  0,  0};

    rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; error_n = '0;
    repeat (3) @(negedge clk);
    chk("rst.phase", int'(phase), 0);
    chk("rst.sym", int'(sym_strobe), 0);
    chk("rst.mid", int'(mid_strobe), 0);
    chk("rst.adj", int'(adj), 0);
    chk("rst.state", int'(state), 0);
    chk("rst.locked", int'(locked), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      en = vecs[i].en_v[0];
      sample_valid = vecs[i].sv[0];
      error_n = 16'(vecs[i].err);
      repeat (vecs[i].ncyc) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.phase", i), int'(phase), vecs[i].ph);
      chk($sformatf("vec%0d.sym", i), int'(sym_strobe), vecs[i].sym);
      chk($sformatf("vec%0d.mid", i), int'(mid_strobe), vecs[i].mid);
      chk($sformatf("vec%0d.adj", i), int'(adj), vecs[i].adjv);
      chk($sformatf("vec%0d.state", i), int'(state), vecs[i].st);
    end

    // Zero error: 32-clock symbols, mid 16 after, no adjustments, TRACK after 256 strobes.
    go_idle();
    en = 1'b1; sample_valid = 1'b1; error_n = '0;
    nsym = 0; last_sym = 0; t256 = -1;
    bad_per = 0; bad_mid = 0; bad_adj = 0; bad_st = 0;
    for (int c = 1; c <= 8300; c++) begin
      cyc1();
      if (adj != 2'b00) bad_adj++;
      if (mid_strobe && c != ((nsym == 0) ? 17 : last_sym + 16)) bad_mid++;
      if (sym_strobe) begin
        nsym++;
        if (nsym > 1 && c - last_sym != 32) bad_per++;
        last_sym = c;
        if (nsym == 256) t256 = c;
      end
      if (t256 > 0 && c == t256 + 1) break;
      if (state != 2'b01) bad_st++;
    end
    chk("acq.nsym", nsym, 256);
    chk("acq.t256", t256, 8193);
    chk("acq.track", int'(state), 2);
    chk("acq.period", bad_per, 0);
    chk("acq.mid", bad_mid, 0);
    chk("acq.adj", bad_adj, 0);
    chk("acq.state", bad_st, 0);

`ifdef GARDNER_LOCK_DET_EN
    chk("lock.on", int'(locked), 1);
    wait_syms(1, 40, ok);
    chk("lock.wait1", ok, 1);
    error_n = 16'sd600;
    cyc1();
    chk("lock.hold", int'(locked), 1);
    error_n = 16'sd100;
    cyc1();
    chk("lock.drop", int'(locked), 0);
    wait_syms(64, 64 * 32 + 40, ok);
    chk("lock.wait64", ok, 1);
    cyc1();
    chk("lock.cnt63", int'(locked), 0);
    cyc1();
    chk("lock.relock", int'(locked), 1);
`else
    error_n = 16'sd100;
    wait_syms(2, 80, ok);
    chk("lock.wait", ok, 1);
    chk("lock.off", int'(locked), 0);
`endif

    // Positive error: skip decided on symbol 2, applied 3 clocks later, 31-clock period.
    go_idle();
    run_meas(4000, 1);
    chk("pos.sym1", t_sym[1], 33);
    chk("pos.sym2", t_sym[2], 65);
    chk("pos.tadj", t_adj, 68);
    chk("pos.adj", adj1, 1);
    chk("pos.phase", ph_adj, 4);
    chk("pos.sym3", t_sym[3], 96);
    chk("pos.sym4", t_sym[4], 128);
    chk("pos.nskip", n_skip, 1);
    chk("pos.nstuff", n_stuff, 0);

    // Negative error: stuff holds the phase, 33-clock period.
    go_idle();
    run_meas(-4000, 1);
    chk("neg.tadj", t_adj, 68);
    chk("neg.adj", adj1, 2);
    chk("neg.phase", ph_adj, 2);
    chk("neg.symadj", sym_at_adj, 0);
    chk("neg.sym3", t_sym[3], 98);
    chk("neg.sym4", t_sym[4], 130);
    chk("neg.nstuff", n_stuff, 1);
    chk("neg.nskip", n_skip, 0);

    // Every third clock valid: everything scales to 96 clocks per symbol.
    go_idle();
    run_meas(0, 3);
    chk("div3.mid1", t_mid1, 49);
    chk("div3.sym1", t_sym[1], 97);
    chk("div3.sym2", t_sym[2], 193);
    chk("div3.sym3", t_sym[3], 289);
    chk("div3.adj", n_skip + n_stuff, 0);

    // Pending skip waits through a long sample_valid gap.
    go_idle();
    en = 1'b1; sample_valid = 1'b1; error_n = 16'sd4000;
    wait_syms(2, 200, ok);
    chk("hold.wait", ok, 1);
    sample_valid = 1'b0;
    bad_hold = 0;
    for (int c = 0; c < 10; c++) begin
      cyc1();
      if (adj != 2'b00 || phase != 5'd0 || sym_strobe || mid_strobe) bad_hold++;
    end
    chk("hold.frozen", bad_hold, 0);
    sample_valid = 1'b1;
    cyc1();
    chk("hold.adj", int'(adj), 1);
    chk("hold.phase", int'(phase), 2);
    cyc1();
    chk("hold.adjclr", int'(adj), 0);
    chk("hold.phase2", int'(phase), 3);

    // Drop en in the filter-update cycle: everything clears and the skip never appears.
    go_idle();
    en = 1'b1; sample_valid = 1'b1; error_n = 16'sd4000;
    wait_syms(2, 200, ok);
    chk("drop.wait", ok, 1);
    cyc1();
    en = 1'b0;
    cyc1();
    chk("drop.state", int'(state), 0);
    chk("drop.phase", int'(phase), 0);
    chk("drop.adj", int'(adj), 0);
    chk("drop.sym", int'(sym_strobe), 0);
    chk("drop.mid", int'(mid_strobe), 0);
    chk("drop.locked", int'(locked), 0);
    cyc1();
    chk("drop.adj2", int'(adj), 0);
    run_meas(4000, 1);
    chk("drop.resym1", t_sym[1], 33);
    chk("drop.retadj", t_adj, 68);
    chk("drop.readj", adj1, 1);

    // Most-negative error must not wrap to a positive correction.
    go_idle();
    run_meas(-32768, 1);
    chk("minerr.adj", adj1, 2);
    chk("minerr.tadj", t_adj, 36);
    chk("minerr.nskip", n_skip, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
